relay_mode_sequencer: RTL and testbench



---
 rtl/relay_mode_sequencer_pkg.sv | 45 ++++
 rtl/relay_mode_sequencer_if.sv | 23 ++
 rtl/relay_mode_sequencer_pattern_match.sv | 49 ++++
 rtl/relay_mode_sequencer.sv | 147 ++++++++++++++
 tb/tb_relay_mode_sequencer.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/relay_mode_sequencer_pkg.sv
// Shared mode codes, frame delimiter patterns and state/role types for the relay sequencer.
package relay_mode_sequencer_pkg;

    // mod_type codes driven to the analogue front-end
    localparam logic [2:0] ModTagsimListen = 3'b001;
    localparam logic [2:0] ModTagsimMod    = 3'b010;
    localparam logic [2:0] ModReaderListen = 3'b011;
    localparam logic [2:0] ModReaderMod    = 3'b100;

    // Role select codes on hi_simulate_mod_type
    localparam logic [2:0] ModeFakeReader  = 3'b101;
    localparam logic [2:0] ModeFakeTag     = 3'b110;

    // Frame delimiters, compared against the 20-bit decoded history
    localparam logic [19:0] RdStartPat  = 20'h0000C;
    localparam logic [19:0] RdEndPatA   = 20'h00000;
    localparam logic [19:0] RdEndPatB   = 20'hC0000;
    localparam logic [19:0] TgStartPat  = 20'h000F0;
    localparam logic [11:0] TgEndPatLow = 12'h000;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StListen = 2'd1,
        StMod    = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        RoleNone   = 2'd0,
        RoleReader = 2'd1,
        RoleTag    = 2'd2
    } role_e;

    // Anything other than the two fake roles is treated as idle.
    function automatic role_e decode_role(input logic [2:0] mode);
        role_e r;
        r = RoleNone;
        if (mode == ModeFakeReader) begin
            r = RoleReader;
        end else if (mode == ModeFakeTag) begin
            r = RoleTag;
        end
        return r;
    endfunction

endpackage

// File: rtl/relay_mode_sequencer_if.sv
// Bit-stream, role-select, mod_type and ARM capture signals of the relay sequencer.
interface relay_mode_sequencer_if;
    logic       bit_strobe;
    logic       bit_in;
    logic [2:0] hi_simulate_mod_type;
    logic       cap_strobe;
    logic [2:0] mod_type;
    logic       frame_active;
    logic       cap_bit;
    logic       cap_ready;

    // Bit source / ARM side
    modport master (
        output bit_strobe, bit_in, hi_simulate_mod_type, cap_strobe,
        input  mod_type, frame_active, cap_bit, cap_ready
    );

    // Sequencer side
    modport slave (
        input  bit_strobe, bit_in, hi_simulate_mod_type, cap_strobe,
        output mod_type, frame_active, cap_bit, cap_ready
    );
endinterface

// File: rtl/relay_mode_sequencer_pattern_match.sv
// Decoded-bit history, bit-in-byte counter and the four frame delimiter comparators.
// Comparators look at the post-shift history and post-increment counter, so they fire
// on the strobe cycle itself.
module relay_mode_sequencer_pattern_match
    import relay_mode_sequencer_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic clear,       // role change: drop history and byte alignment
    input  logic bcnt_load,   // frame start: realign byte counter to zero
    input  logic bit_strobe,
    input  logic bit_in,
    output logic rd_start,
    output logic rd_end,
    output logic tg_start,
    output logic tg_end
);

    logic [19:0] hist_q;
    logic [19:0] hist_shift;
    logic [2:0]  bcnt_q;
    logic [2:0]  bcnt_inc;
    logic        byte_aligned;

    assign hist_shift   = {hist_q[18:0], bit_in};
    assign bcnt_inc     = bcnt_q + 3'd1;
    assign byte_aligned = (bcnt_inc == 3'd0);

    // History shift and byte counter advance on every decoded bit.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hist_q <= '0;
            bcnt_q <= '0;
        end else if (bit_strobe) begin
            hist_q <= hist_shift;
            bcnt_q <= bcnt_load ? 3'd0 : bcnt_inc;
        end
    end

    // Delimiter comparators, qualified by the strobe.
    always_comb begin
        rd_start = bit_strobe && (hist_shift == RdStartPat);
        rd_end   = bit_strobe && byte_aligned &&
                   ((hist_shift == RdEndPatA) || (hist_shift == RdEndPatB));
        tg_start = bit_strobe && (hist_shift == TgStartPat);
        tg_end   = bit_strobe && byte_aligned && (hist_shift[11:0] == TgEndPatLow);
    end

endmodule

// File: rtl/relay_mode_sequencer.sv
// Relay front-end sequencer: LISTEN/MOD state machine per fake role, MOD watchdog and the
// fake-reader capture buffer that is drained MSB-first to the ARM.
module relay_mode_sequencer
    import relay_mode_sequencer_pkg::*;
#(
    parameter int unsigned CAP_BITS       = 80,
    parameter int unsigned MAX_FRAME_BITS = 4096,
    parameter int unsigned WD_W           = 13
) (
    input  logic                   clk,
    input  logic                   reset,
    relay_mode_sequencer_if.slave  bus
);

    localparam int unsigned CcntW = $clog2(CAP_BITS + 1);
    localparam logic [CcntW-1:0] CapMax = CcntW'(CAP_BITS);
    localparam logic [WD_W-1:0]  WdMax  = WD_W'(MAX_FRAME_BITS);

    state_e state_q, state_d;
    role_e  role, role_q;
    logic   role_change;

    logic [WD_W-1:0] wd_q, wd_d, wd_inc;
    logic [2:0]      mod_type_q, mod_type_d;
    logic            frame_active_q, frame_active_d;
    logic            bcnt_load;
    logic            start_hit, end_hit;
    logic            rd_start, rd_end, tg_start, tg_end;

    logic [CAP_BITS-1:0] cap_buf_q;
    logic [CcntW-1:0]    ccnt_q, ccnt_inc;
    logic                cap_ready_q;

    assign role        = decode_role(bus.hi_simulate_mod_type);
    assign role_change = (role != role_q);
    assign wd_inc      = wd_q + 1'b1;
    assign ccnt_inc    = ccnt_q + 1'b1;

    relay_mode_sequencer_pattern_match u_match (
        .clk        (clk),
        .reset      (reset),
        .clear      (role_change),
        .bcnt_load  (bcnt_load),
        .bit_strobe (bus.bit_strobe),
        .bit_in     (bus.bit_in),
        .rd_start   (rd_start),
        .rd_end     (rd_end),
        .tg_start   (tg_start),
        .tg_end     (tg_end)
    );

    // State, role history, watchdog and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StIdle;
            role_q         <= RoleNone;
            wd_q           <= '0;
            mod_type_q     <= ModReaderListen;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            role_q         <= role;
            wd_q           <= wd_d;
            mod_type_q     <= mod_type_d;
            frame_active_q <= frame_active_d;
        end
    end

    // Next state and next mod code; a role change always wins and parks in IDLE for a cycle.
    always_comb begin
        state_d   = state_q;
        wd_d      = wd_q;
        bcnt_load = 1'b0;
        start_hit = (role == RoleTag) ? tg_start : rd_start;
        end_hit   = (role == RoleTag) ? tg_end   : rd_end;

        if (role_change) begin
            state_d = StIdle;
            wd_d    = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (role != RoleNone) begin
                        state_d = StListen;
                    end
                end
                StListen: begin
                    if (start_hit) begin
                        state_d   = StMod;
                        bcnt_load = 1'b1;
                        wd_d      = '0;
                    end
                end
                StMod: begin
                    if (bus.bit_strobe) begin
                        wd_d = wd_inc;
                        // Runaway frame: watchdog forces LISTEN regardless of delimiters.
                        if (wd_inc == WdMax || end_hit) begin
                            state_d = StListen;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        mod_type_d = ModReaderListen;
        if (state_d == StListen) begin
            mod_type_d = (role == RoleTag) ? ModTagsimListen : ModReaderListen;
        end else if (state_d == StMod) begin
            mod_type_d = (role == RoleTag) ? ModTagsimMod : ModReaderMod;
        end
        frame_active_d = (state_d == StMod);
    end

    // Capture buffer: fill from the bit stream, then drain to the ARM on cap_strobe.
    always_ff @(posedge clk) begin
        if (reset || role != RoleReader) begin
            cap_buf_q   <= '0;
            ccnt_q      <= '0;
            cap_ready_q <= 1'b0;
        end else if (state_q != StIdle && !role_change) begin
            if (cap_ready_q) begin
                if (bus.cap_strobe) begin
                    if (ccnt_inc == CapMax) begin
                        cap_buf_q   <= '0;
                        ccnt_q      <= '0;
                        cap_ready_q <= 1'b0;
                    end else begin
                        cap_buf_q <= {cap_buf_q[CAP_BITS-2:0], 1'b0};
                        ccnt_q    <= ccnt_inc;
                    end
                end
            end else if (bus.bit_strobe) begin
                cap_buf_q   <= {cap_buf_q[CAP_BITS-2:0], bus.bit_in};
                ccnt_q      <= (ccnt_inc == CapMax) ? '0 : ccnt_inc;
                cap_ready_q <= (ccnt_inc == CapMax);
            end
        end
    end

    assign bus.mod_type     = mod_type_q;
    assign bus.frame_active = frame_active_q;
    assign bus.cap_bit      = cap_buf_q[CAP_BITS-1];
    assign bus.cap_ready    = cap_ready_q;

endmodule

// File: tb/tb_relay_mode_sequencer.sv
// Self-checking bench for relay_mode_sequencer: a vector table for the fake-tag role plus
// hand-written sequences for reader framing, watchdog, role switch, capture and reset.
module tb_relay_mode_sequencer;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    relay_mode_sequencer_if bus ();

    relay_mode_sequencer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [2:0] role;
        logic       bs;
        logic       bi;
        logic       cs;
        logic [2:0] exp_mt;
        logic       exp_fa;
        logic       exp_cr;
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic rst, input logic [2:0] role, input logic bs,
                                input logic bi, input logic cs, input logic [2:0] mt,
                                input logic fa, input logic cr, input string nm);
        vec_t v;
        v.rst = rst; v.role = role; v.bs = bs; v.bi = bi; v.cs = cs;
        v.exp_mt = mt; v.exp_fa = fa; v.exp_cr = cr; v.name = nm;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock: drive on the falling edge, outputs settle 1 time unit after the rising edge.
    task automatic cyc(input logic rst, input logic [2:0] role, input logic bs, input logic bi,
                       input logic cs);
        @(negedge clk);
        reset                    = rst;
        bus.hi_simulate_mod_type = role;
        bus.bit_strobe           = bs;
        bus.bit_in               = bi;
        bus.cap_strobe           = cs;
        @(posedge clk);
        #1;
    endtask

    // Reset, then two cycles with the role held: IDLE (role change) then LISTEN.
    task automatic enter_listen(input logic [2:0] role);
        cyc(1'b1, role, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, role, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, role, 1'b0, 1'b0, 1'b0);
    endtask

    // 8 ones, 68 zeros, 1100: exactly CAP_BITS bits ending in the reader start delimiter.
    task automatic fill_to_mod();
        for (int i = 0; i < 8; i++)  cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 68; i++) cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] pat;
        pat                      = 8'hA5;
        reset                    = 1'b1;
        bus.hi_simulate_mod_type = 3'b000;
        bus.bit_strobe           = 1'b0;
        bus.bit_in               = 1'b0;
        bus.cap_strobe           = 1'b0;

        // ---------------- fake-tag vector table ----------------
        add(1, 3'b000, 0, 0, 0, 3'b011, 0, 0, "reset");
        add(0, 3'b000, 0, 0, 0, 3'b011, 0, 0, "idle_none");
        add(0, 3'b111, 0, 0, 0, 3'b011, 0, 0, "idle_111");
        add(0, 3'b110, 0, 0, 0, 3'b011, 0, 0, "tag_chg");
        add(0, 3'b110, 0, 0, 0, 3'b001, 0, 0, "tag_listen");
        for (int i = 0; i < 4; i++) add(0, 3'b110, 1, 1, 0, 3'b001, 0, 0, "tag_ones");
        add(0, 3'b110, 0, 0, 0, 3'b001, 0, 0, "tag_gap");
        for (int i = 0; i < 3; i++) add(0, 3'b110, 1, 0, 0, 3'b001, 0, 0, "tag_zeros");
        add(0, 3'b110, 1, 0, 0, 3'b010, 1, 0, "tag_start");
        for (int i = 0; i < 7; i++) add(0, 3'b110, 1, 0, 0, 3'b010, 1, 0, "tag_body");
        add(0, 3'b110, 1, 0, 0, 3'b001, 0, 0, "tag_end");
        // Restart, then misalign by one bit: hist[11:0] clears at bcnt 5, end waits to bcnt 0.
        for (int i = 0; i < 4; i++) add(0, 3'b110, 1, 1, 0, 3'b001, 0, 0, "tag_ones2");
        for (int i = 0; i < 3; i++) add(0, 3'b110, 1, 0, 0, 3'b001, 0, 0, "tag_zeros2");
        add(0, 3'b110, 1, 0, 0, 3'b010, 1, 0, "tag_restart");
        add(0, 3'b110, 1, 1, 0, 3'b010, 1, 0, "tag_one");
        for (int i = 0; i < 14; i++) add(0, 3'b110, 1, 0, 0, 3'b010, 1, 0, "tag_bcnt_gate");
        add(0, 3'b110, 1, 0, 0, 3'b001, 0, 0, "tag_end2");

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].role, vecs[i].bs, vecs[i].bi, vecs[i].cs);
            check({vecs[i].name, "_mt"}, bus.mod_type, vecs[i].exp_mt);
            check({vecs[i].name, "_fa"}, bus.frame_active, vecs[i].exp_fa);
            check({vecs[i].name, "_cr"}, bus.cap_ready, vecs[i].exp_cr);
        end

        // ---------------- reader framing ----------------
        cyc(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        check("rst_mt", bus.mod_type, 3'b011);
        check("rst_fa", bus.frame_active, 1'b0);
        check("rst_cb", bus.cap_bit, 1'b0);
        check("rst_cr", bus.cap_ready, 1'b0);
        cyc(1'b0, 3'b101, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 3'b101, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        check("rd_pre_start_fa", bus.frame_active, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        check("rd_start_mt", bus.mod_type, 3'b100);
        check("rd_start_fa", bus.frame_active, 1'b1);
        for (int i = 0; i < 15; i++) cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        check("rd_body_mt", bus.mod_type, 3'b100);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        check("rd_end_mt", bus.mod_type, 3'b011);
        check("rd_end_fa", bus.frame_active, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        check("rd_listen_hold_fa", bus.frame_active, 1'b0);

        // ---------------- MOD watchdog ----------------
        enter_listen(3'b101);
        for (int i = 0; i < 4; i++) cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, 1'b0, 1'b0);
        check("wd_start_mt", bus.mod_type, 3'b100);
        for (int i = 0; i < 4095; i++) cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        check("wd_4095_mt", bus.mod_type, 3'b100);
        cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        check("wd_4096_mt", bus.mod_type, 3'b011);
        check("wd_4096_fa", bus.frame_active, 1'b0);

        // ---------------- role switch mid-MOD ----------------
        enter_listen(3'b101);
        fill_to_mod();
        check("sw_mod_mt", bus.mod_type, 3'b100);
        check("sw_cap_ready", bus.cap_ready, 1'b1);
        check("sw_cap_bit", bus.cap_bit, 1'b1);
        cyc(1'b0, 3'b110, 1'b0, 1'b0, 1'b0);
        check("sw_next_mt", bus.mod_type, 3'b011);
        check("sw_next_fa", bus.frame_active, 1'b0);
        check("sw_next_cr", bus.cap_ready, 1'b0);
        check("sw_next_cb", bus.cap_bit, 1'b0);
        cyc(1'b0, 3'b110, 1'b0, 1'b0, 1'b0);
        check("sw_after_mt", bus.mod_type, 3'b001);

        // ---------------- capture and drain ----------------
        enter_listen(3'b101);
        for (int i = 0; i < 40; i++) cyc(1'b0, 3'b101, 1'b1, pat[7 - (i % 8)], 1'b0);
        cyc(1'b0, 3'b101, 1'b0, 1'b0, 1'b1);
        check("cap_early_strobe_cr", bus.cap_ready, 1'b0);
        for (int i = 40; i < 79; i++) cyc(1'b0, 3'b101, 1'b1, pat[7 - (i % 8)], 1'b0);
        check("cap_79_cr", bus.cap_ready, 1'b0);
        cyc(1'b0, 3'b101, 1'b1, pat[0], 1'b0);
        check("cap_80_cr", bus.cap_ready, 1'b1);
        for (int i = 0; i < 80; i++) begin
            check($sformatf("drain_bit%0d", i), bus.cap_bit, pat[7 - (i % 8)]);
            if (i == 40) check("drain_mid_cr", bus.cap_ready, 1'b1);
            cyc(1'b0, 3'b101, (i % 3) == 0, 1'b1, 1'b1);
        end
        check("drain_done_cr", bus.cap_ready, 1'b0);
        check("drain_done_cb", bus.cap_bit, 1'b0);
        for (int i = 0; i < 80; i++) cyc(1'b0, 3'b101, 1'b1, 1'b1, 1'b0);
        check("rearm_cr", bus.cap_ready, 1'b1);
        check("rearm_cb", bus.cap_bit, 1'b1);

        // ---------------- reset mid-MOD and mid-drain ----------------
        enter_listen(3'b101);
        fill_to_mod();
        for (int i = 0; i < 3; i++) cyc(1'b0, 3'b101, 1'b0, 1'b0, 1'b1);
        check("mid_drain_cb", bus.cap_bit, 1'b1);
        check("mid_drain_fa", bus.frame_active, 1'b1);
        cyc(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
        check("rst2_mt", bus.mod_type, 3'b011);
        check("rst2_fa", bus.frame_active, 1'b0);
        check("rst2_cb", bus.cap_bit, 1'b0);
        check("rst2_cr", bus.cap_ready, 1'b0);
        cyc(1'b0, 3'b101, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 3'b101, 1'b0, 1'b0, 1'b1);
        check("rst2_after_cr", bus.cap_ready, 1'b0);
        check("rst2_after_fa", bus.frame_active, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
